brick_hit_handler: RTL and testbench
====================================

Name: brick_hit_handler

Overview:
- Downstream of the ball collision stage.
- Consumes its two brick-collision reports: channel 1 is vertical (y-bounce), channel 2 is horizontal (x-bounce), each with brick pixel coordinates.
- Per brick hit, does one read-modify-write of the brick health RAM, then requests a brick redraw (recolour or erase) from the draw stage.
- Tracks bricks remaining and flags level clear.

Parameters:
- GRID_X, 16, bricks per row.
- GRID_Y, 4, brick rows.
- BRICK_W, 4, brick width in pixels (power of two).
- BRICK_H, 2, brick height in pixels (power of two).
- NUM_BRICKS, 64, GRID_X*GRID_Y; reset value of the remaining counter.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous, active-low reset.
- col1_valid  in  1  one-cycle pulse: vertical collision reported.
- col_x1  in  10  pixel x of the collided brick, channel 1.
- col_y1  in  10  pixel y of the collided brick, channel 1.
- col2_valid  in  1  one-cycle pulse: horizontal collision reported.
- col_x2  in  10  pixel x of the collided brick, channel 2.
- col_y2  in  10  pixel y of the collided brick, channel 2.
- mem_addr  out  6  brick RAM address.
- mem_we  out  1  brick RAM write enable.
- mem_wdata  out  2  health written.
- mem_rdata  in  2  health read; valid exactly 1 cycle after mem_addr is presented.
- draw_req  out  1  redraw request, held until draw_ack.
- draw_x  out  10  brick pixel x, aligned to BRICK_W.
- draw_y  out  10  brick pixel y, aligned to BRICK_H.
- draw_health  out  2  new health; 0 means erase.
- draw_ack  in  1  one-cycle pulse from the draw stage: request accepted.
- busy  out  1  FSM not in IDLE, or any pending slot full.
- bricks_left  out  7  bricks with health > 0.
- all_cleared  out  1  bricks_left == 0.
- overflow  out  1  sticky: a hit was dropped.

Behaviour:
- Reset (async, resetn=0), all outputs:
  - mem_addr=0, mem_we=0, mem_wdata=0.
  - draw_req=0, draw_x=0, draw_y=0, draw_health=0.
  - busy=0, bricks_left=NUM_BRICKS, all_cleared=0, overflow=0.
  - Both pending slots empty; FSM in IDLE.
  - Reset mid-operation aborts any RMW or draw request. No write completes after resetn falls.
- Index computation: idx = (y/BRICK_H)*GRID_X + (x/BRICK_W), using shifts.
  - Coordinates with x >= GRID_X*BRICK_W or y >= GRID_Y*BRICK_H are ignored; no slot is filled.
- Pending slots: two, P1 fed by channel 1 and P2 fed by channel 2. Each holds a valid bit and idx.
  - A valid pulse loads its slot on the same edge.
  - Pulse while the slot is full: the event is dropped and overflow is set. It clears only on reset.
  - Both pulses in one cycle with equal idx: only P1 is loaded (one decrement per brick per event pair).
  - Also dropped silently, without setting overflow: an incoming idx equal to the idx currently being processed, or equal to the other slot's idx.
- FSM states: IDLE, READ, CALC, WRITE, DRAW.
  - IDLE: if P1 is valid, select P1; else if P2 is valid, select P2. Selecting clears that slot, latches idx, and moves to READ. Otherwise stay in IDLE.
  - READ: mem_addr=idx. Go to CALC.
  - CALC: capture mem_rdata as h.
    - h==0 (already destroyed): go to IDLE; no write, no draw.
    - Otherwise: nh = h-1. Go to WRITE.
  - WRITE: mem_we=1 for exactly one cycle with mem_wdata=nh. If nh==0, decrement bricks_left. Go to DRAW.
  - DRAW: draw_req=1; draw_x=(idx%GRID_X)*BRICK_W, draw_y=(idx/GRID_X)*BRICK_H, draw_health=nh.
    - draw_x, draw_y and draw_health are stable while draw_req is high.
    - On draw_ack: draw_req=0 on the next edge, go to IDLE.
    - draw_ack outside DRAW is ignored.
- Latency: a hit into an empty handler with immediate ack gives mem_we 3 cycles after the valid pulse, and draw_req in the cycle after mem_we.
- bricks_left saturates at 0. all_cleared is combinational from bricks_left.
- The handler is not the RAM's only user. mem_we is asserted only in WRITE.

Decomposition:
- Shared package/header holds the GRIDX/GRIDY/BRICKX/BRICKY/BRICKNUM constants, already used by the collision stage. Add HIT_IDLE..HIT_DRAW state encodings (3-bit).
- One natural sub-module: brick_hit_index. Combinational pixel-to-idx conversion plus the in-range check, instantiated twice, once per channel.

Test Plan:
- Basic hit:
  - Stimulus: RAM idx 18 holds 2; col1_valid with x=8, y=2.
  - Required: mem_addr=18; mem_we with wdata=1; draw_req with draw_x=8, draw_y=2, draw_health=1; bricks_left stays 64.
- Destroy:
  - Stimulus: idx 0 holds 1; col2_valid with x=0, y=0; ack after 5 cycles.
  - Required: wdata=0; bricks_left=63; draw_health=0; draw_req held 5 cycles, then IDLE.
- Simultaneous:
  - Stimulus: col1 (4,0) and col2 (0,2) in the same cycle.
  - Required: idx 1 is processed, then idx 16; two writes, two draws, in that order.
- Duplicate and dead brick:
  - Stimulus: col1 and col2 both at (12,6), idx 51 holding 3.
  - Required: one write, wdata=2.
  - Stimulus: a brick holding 0 is hit.
  - Required: no mem_we, no draw_req.
- Overflow and range:
  - Stimulus: two col1 pulses while busy with a different idx.
  - Required: overflow=1; the second hit is lost.
  - Stimulus: x=64.
  - Required: ignored.
- Reset mid-DRAW:
  - Stimulus: resetn low while draw_req=1.
  - Required: draw_req=0 immediately; bricks_left=64; slots empty.

Source files
------------

// File: rtl/brick_hit_handler_pkg.sv
// Shared brick-field geometry and hit-handler FSM encodings.
// The geometry constants are also used by the collision stage.
package brick_hit_handler_pkg;

    localparam int GRIDX    = 16;
    localparam int GRIDY    = 4;
    localparam int BRICKX   = 4;
    localparam int BRICKY   = 2;
    localparam int BRICKNUM = GRIDX * GRIDY;

    localparam logic [2:0] HIT_IDLE  = 3'd0;
    localparam logic [2:0] HIT_READ  = 3'd1;
    localparam logic [2:0] HIT_CALC  = 3'd2;
    localparam logic [2:0] HIT_WRITE = 3'd3;
    localparam logic [2:0] HIT_DRAW  = 3'd4;

endpackage

// File: rtl/brick_hit_index.sv
// Pixel coordinate to brick index, plus the in-field check.
// Brick sizes are powers of two, so the divides reduce to shifts.
module brick_hit_index
    import brick_hit_handler_pkg::*;
#(
    parameter int GRID_X  = GRIDX,
    parameter int GRID_Y  = GRIDY,
    parameter int BRICK_W = BRICKX,
    parameter int BRICK_H = BRICKY,
    parameter int IDX_W   = $clog2(GRIDX * GRIDY)
) (
    input  logic [9:0]       x,
    input  logic [9:0]       y,
    output logic [IDX_W-1:0] idx,
    output logic             in_range
);
    localparam int SH_X = $clog2(BRICK_W);
    localparam int SH_Y = $clog2(BRICK_H);

    logic [9:0] col;
    logic [9:0] row;

    assign col      = x >> SH_X;
    assign row      = y >> SH_Y;
    assign idx      = IDX_W'(row * 10'(GRID_X) + col);
    assign in_range = (x < 10'(GRID_X * BRICK_W)) && (y < 10'(GRID_Y * BRICK_H));

endmodule

// File: rtl/brick_hit_handler.sv
// Turns brick collision reports into one health RMW per hit plus a redraw
// request; tracks bricks remaining and flags level clear.
module brick_hit_handler
    import brick_hit_handler_pkg::*;
#(
    parameter int GRID_X     = GRIDX,
    parameter int GRID_Y     = GRIDY,
    parameter int BRICK_W    = BRICKX,
    parameter int BRICK_H    = BRICKY,
    parameter int NUM_BRICKS = GRID_X * GRID_Y
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              col1_valid,
    input  logic [9:0]                        col_x1,
    input  logic [9:0]                        col_y1,
    input  logic                              col2_valid,
    input  logic [9:0]                        col_x2,
    input  logic [9:0]                        col_y2,
    output logic [$clog2(NUM_BRICKS)-1:0]     mem_addr,
    output logic                              mem_we,
    output logic [1:0]                        mem_wdata,
    input  logic [1:0]                        mem_rdata,
    output logic                              draw_req,
    output logic [9:0]                        draw_x,
    output logic [9:0]                        draw_y,
    output logic [1:0]                        draw_health,
    input  logic                              draw_ack,
    output logic                              busy,
    output logic [$clog2(NUM_BRICKS+1)-1:0]   bricks_left,
    output logic                              all_cleared,
    output logic                              overflow
);
    localparam int IDX_W = $clog2(NUM_BRICKS);
    localparam int CNT_W = $clog2(NUM_BRICKS + 1);

    logic [IDX_W-1:0] idx1, idx2;
    logic             rng1, rng2;

    brick_hit_index #(
        .GRID_X(GRID_X), .GRID_Y(GRID_Y), .BRICK_W(BRICK_W), .BRICK_H(BRICK_H), .IDX_W(IDX_W)
    ) u_idx1 (.x(col_x1), .y(col_y1), .idx(idx1), .in_range(rng1));

    brick_hit_index #(
        .GRID_X(GRID_X), .GRID_Y(GRID_Y), .BRICK_W(BRICK_W), .BRICK_H(BRICK_H), .IDX_W(IDX_W)
    ) u_idx2 (.x(col_x2), .y(col_y2), .idx(idx2), .in_range(rng2));

    logic [2:0]       state;
    logic             p1_vld, p2_vld;
    logic [IDX_W-1:0] p1_idx, p2_idx, cur_idx;
    logic [1:0]       nh;
    logic [9:0]       cur_ext;

    logic             idle, act_vld;
    logic [IDX_W-1:0] act_idx;
    logic             hit1, hit2, sel_p1, sel_p2, byp1, byp2;
    logic             full1, full2, load1, load2, drop;

    assign idle    = (state == HIT_IDLE);
    assign cur_ext = 10'(cur_idx);

    // act_idx is the brick in flight, or the one IDLE is about to pick.
    always_comb begin
        act_vld = !idle || p1_vld || p2_vld;
        act_idx = !idle ? cur_idx : (p1_vld ? p1_idx : p2_idx);
        hit1 = col1_valid && rng1
               && !(act_vld && idx1 == act_idx)
               && !(p2_vld && idx1 == p2_idx);
        hit2 = col2_valid && rng2
               && !(act_vld && idx2 == act_idx)
               && !(p1_vld && idx2 == p1_idx)
               && !(col1_valid && rng1 && idx1 == idx2);
        sel_p1 = idle && p1_vld;
        sel_p2 = idle && !p1_vld && p2_vld;
        // With both slots empty, IDLE takes a fresh hit straight to READ.
        byp1  = idle && !p1_vld && !p2_vld && hit1;
        byp2  = idle && !p1_vld && !p2_vld && !hit1 && hit2;
        full1 = p1_vld && !sel_p1;
        full2 = p2_vld && !sel_p2;
        load1 = hit1 && !byp1 && !full1;
        load2 = hit2 && !byp2 && !full2;
        drop  = (hit1 && !byp1 && full1) || (hit2 && !byp2 && full2);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= HIT_IDLE;
            p1_vld      <= 1'b0;
            p2_vld      <= 1'b0;
            p1_idx      <= '0;
            p2_idx      <= '0;
            cur_idx     <= '0;
            nh          <= 2'd0;
            draw_req    <= 1'b0;
            draw_x      <= 10'd0;
            draw_y      <= 10'd0;
            draw_health <= 2'd0;
            bricks_left <= CNT_W'(NUM_BRICKS);
            overflow    <= 1'b0;
        end else begin
            if (load1) begin
                p1_vld <= 1'b1;
                p1_idx <= idx1;
            end else if (sel_p1) begin
                p1_vld <= 1'b0;
            end
            if (load2) begin
                p2_vld <= 1'b1;
                p2_idx <= idx2;
            end else if (sel_p2) begin
                p2_vld <= 1'b0;
            end
            if (drop) overflow <= 1'b1;

            case (state)
                HIT_IDLE: begin
                    if (sel_p1) begin
                        cur_idx <= p1_idx;
                        state   <= HIT_READ;
                    end else if (sel_p2) begin
                        cur_idx <= p2_idx;
                        state   <= HIT_READ;
                    end else if (byp1) begin
                        cur_idx <= idx1;
                        state   <= HIT_READ;
                    end else if (byp2) begin
                        cur_idx <= idx2;
                        state   <= HIT_READ;
                    end
                end
                HIT_READ: state <= HIT_CALC;
                HIT_CALC: begin
                    if (mem_rdata == 2'd0) begin
                        state <= HIT_IDLE;
                    end else begin
                        nh    <= mem_rdata - 2'd1;
                        state <= HIT_WRITE;
                    end
                end
                HIT_WRITE: begin
                    if (nh == 2'd0 && bricks_left != '0) bricks_left <= bricks_left - CNT_W'(1);
                    draw_req    <= 1'b1;
                    draw_x      <= (cur_ext % 10'(GRID_X)) * 10'(BRICK_W);
                    draw_y      <= (cur_ext / 10'(GRID_X)) * 10'(BRICK_H);
                    draw_health <= nh;
                    state       <= HIT_DRAW;
                end
                HIT_DRAW: begin
                    if (draw_ack) begin
                        draw_req <= 1'b0;
                        state    <= HIT_IDLE;
                    end
                end
                default: state <= HIT_IDLE;
            endcase
        end
    end

    assign mem_addr    = cur_idx;
    assign mem_we      = (state == HIT_WRITE);
    assign mem_wdata   = nh;
    assign busy        = !idle || p1_vld || p2_vld;
    assign all_cleared = (bricks_left == '0);

endmodule

// File: tb/tb_brick_hit_handler.sv
// Directed bench for brick_hit_handler: vector table of single hits plus
// hand sequences for simultaneous, duplicate, overflow, reset and clear.
module tb_brick_hit_handler;

    logic       clk, resetn;
    logic       col1_valid, col2_valid;
    logic [9:0] col_x1, col_y1, col_x2, col_y2;
    logic [5:0] mem_addr;
    logic       mem_we;
    logic [1:0] mem_wdata, mem_rdata;
    logic       draw_req, draw_ack;
    logic [9:0] draw_x, draw_y;
    logic [1:0] draw_health;
    logic       busy, all_cleared, overflow;
    logic [6:0] bricks_left;

    brick_hit_handler dut (
        .clk(clk), .resetn(resetn),
        .col1_valid(col1_valid), .col_x1(col_x1), .col_y1(col_y1),
        .col2_valid(col2_valid), .col_x2(col_x2), .col_y2(col_y2),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .draw_req(draw_req), .draw_x(draw_x), .draw_y(draw_y), .draw_health(draw_health),
        .draw_ack(draw_ack), .busy(busy), .bricks_left(bricks_left),
        .all_cleared(all_cleared), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: 1-cycle read latency; preload port owned by the main sequence.
    logic [1:0] ram [64];
    logic       pre_en;
    logic [5:0] pre_addr;
    logic [1:0] pre_val;
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        else if (pre_en) ram[pre_addr] <= pre_val;
        mem_rdata <= ram[mem_addr];
    end

    int checks = 0, errors = 0;
    int cyc, ack_delay, ack_cnt, cur_len, stab_err;
    logic prev_req;
    logic [21:0] last_draw;
    int wr_addr[$], wr_data[$], wr_cyc[$];
    int dr_x[$], dr_y[$], dr_h[$], dr_cyc[$], dr_len[$];

    // Monitor and draw-stage model, sampled 1 time unit after each edge.
    initial begin
        draw_ack = 1'b0; ack_cnt = 0; cur_len = 0; cyc = 0; stab_err = 0;
        prev_req = 1'b0; last_draw = '0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (mem_we) begin
                wr_addr.push_back(int'(mem_addr));
                wr_data.push_back(int'(mem_wdata));
                wr_cyc.push_back(cyc);
            end
            if (draw_req && !prev_req) begin
                dr_x.push_back(int'(draw_x));
                dr_y.push_back(int'(draw_y));
                dr_h.push_back(int'(draw_health));
                dr_cyc.push_back(cyc);
            end
            if (draw_req && prev_req && {draw_x, draw_y, draw_health} != last_draw) stab_err++;
            if (draw_req) cur_len++;
            else if (prev_req) begin
                dr_len.push_back(cur_len);
                cur_len = 0;
            end
            last_draw = {draw_x, draw_y, draw_health};
            prev_req  = draw_req;
            if (draw_req) begin
                draw_ack = (ack_cnt == ack_delay);
                ack_cnt++;
            end else begin
                draw_ack = 1'b0;
                ack_cnt  = 0;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic clear_logs();
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
        dr_x.delete(); dr_y.delete(); dr_h.delete(); dr_cyc.delete(); dr_len.delete();
    endtask

    task automatic preload(input int a, input logic [1:0] v);
        pre_en = 1'b1; pre_addr = 6'(a); pre_val = v;
        tick();
        pre_en = 1'b0;
    endtask

    task automatic pulse(input int ch, input logic [9:0] x, input logic [9:0] y);
        if (ch == 1) begin col1_valid = 1'b1; col_x1 = x; col_y1 = y; end
        else begin col2_valid = 1'b1; col_x2 = x; col_y2 = y; end
        tick();
        col1_valid = 1'b0; col2_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin tick(); n++; end
        if (busy) chk("idle_timeout", 1, 0);
    endtask

    typedef struct {
        int ch; logic [9:0] x; logic [9:0] y;
        int pidx; logic [1:0] ph; int ackd;
        int nwr; int wdata; int ndr; int dx; int dy; int dh; int left;
    } vec_t;
    vec_t vt[7];

    initial begin
        //          ch  x       y       pidx hp    ack wr wd dr dx dy dh left
        vt[0] = '{1, 10'd8,  10'd2,  18, 2'd2, 0, 1, 1, 1, 8,  2, 1, 64};
        vt[1] = '{2, 10'd0,  10'd0,  0,  2'd1, 4, 1, 0, 1, 0,  0, 0, 63};
        vt[2] = '{1, 10'd63, 10'd7,  63, 2'd3, 0, 1, 2, 1, 60, 6, 2, 63};
        vt[3] = '{2, 10'd20, 10'd4,  37, 2'd0, 0, 0, 0, 0, 0,  0, 0, 63};
        vt[4] = '{1, 10'd64, 10'd0,  40, 2'd3, 0, 0, 0, 0, 0,  0, 0, 63};
        vt[5] = '{2, 10'd0,  10'd8,  41, 2'd3, 0, 0, 0, 0, 0,  0, 0, 63};
        vt[6] = '{2, 10'd5,  10'd1,  1,  2'd3, 0, 1, 2, 1, 4,  0, 2, 63};

        resetn = 1'b0; col1_valid = 1'b0; col2_valid = 1'b0;
        col_x1 = '0; col_y1 = '0; col_x2 = '0; col_y2 = '0;
        pre_en = 1'b0; pre_addr = '0; pre_val = '0; ack_delay = 0;
        tick(); tick();
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_mem_we", int'(mem_we), 0);
        chk("rst_mem_wdata", int'(mem_wdata), 0);
        chk("rst_draw_req", int'(draw_req), 0);
        chk("rst_draw_xyh", int'({draw_x, draw_y, draw_health}), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_bricks_left", int'(bricks_left), 64);
        chk("rst_all_cleared", int'(all_cleared), 0);
        chk("rst_overflow", int'(overflow), 0);
        resetn = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            int p_cyc;
            preload(vt[i].pidx, vt[i].ph);
            clear_logs();
            ack_delay = vt[i].ackd;
            p_cyc = cyc;
            pulse(vt[i].ch, vt[i].x, vt[i].y);
            wait_idle(40);
            chk($sformatf("v%0d_nwrites", i), wr_addr.size(), vt[i].nwr);
            if (vt[i].nwr > 0 && wr_addr.size() > 0) begin
                chk($sformatf("v%0d_addr", i), wr_addr[0], vt[i].pidx);
                chk($sformatf("v%0d_wdata", i), wr_data[0], vt[i].wdata);
                chk($sformatf("v%0d_we_latency", i), wr_cyc[0] - p_cyc, 3);
            end
            chk($sformatf("v%0d_ndraws", i), dr_x.size(), vt[i].ndr);
            if (vt[i].ndr > 0 && dr_x.size() > 0 && wr_cyc.size() > 0 && dr_len.size() > 0) begin
                chk($sformatf("v%0d_draw_x", i), dr_x[0], vt[i].dx);
                chk($sformatf("v%0d_draw_y", i), dr_y[0], vt[i].dy);
                chk($sformatf("v%0d_draw_h", i), dr_h[0], vt[i].dh);
                chk($sformatf("v%0d_draw_after_we", i), dr_cyc[0] - wr_cyc[0], 1);
                chk($sformatf("v%0d_req_len", i), dr_len[0], vt[i].ackd + 1);
            end
            chk($sformatf("v%0d_bricks_left", i), int'(bricks_left), vt[i].left);
        end

        // Simultaneous distinct hits: channel 1 first.
        preload(1, 2'd3); preload(16, 2'd3);
        clear_logs(); ack_delay = 0;
        col2_valid = 1'b1; col_x2 = 10'd0; col_y2 = 10'd2;
        pulse(1, 10'd4, 10'd0);
        wait_idle(60);
        chk("sim_nwrites", wr_addr.size(), 2);
        chk("sim_ndraws", dr_x.size(), 2);
        if (wr_addr.size() == 2 && dr_x.size() == 2) begin
            chk("sim_addr0", wr_addr[0], 1);
            chk("sim_addr1", wr_addr[1], 16);
            chk("sim_draw0", dr_x[0] * 1000 + dr_y[0], 4000);
            chk("sim_draw1", dr_x[1] * 1000 + dr_y[1], 2);
        end

        // Same brick on both channels: one RMW.
        preload(51, 2'd3);
        clear_logs();
        col2_valid = 1'b1; col_x2 = 10'd12; col_y2 = 10'd6;
        pulse(1, 10'd12, 10'd6);
        wait_idle(60);
        chk("dup_nwrites", wr_addr.size(), 1);
        if (wr_addr.size() > 0) chk("dup_wdata", wr_data[0], 2);

        // Refill of a full P1 while busy on another brick.
        preload(10, 2'd3); preload(20, 2'd3); preload(21, 2'd3);
        clear_logs(); ack_delay = 6;
        pulse(1, 10'd40, 10'd0);
        pulse(1, 10'd16, 10'd2);
        chk("ovf_before", int'(overflow), 0);
        pulse(1, 10'd20, 10'd2);
        chk("ovf_set", int'(overflow), 1);
        wait_idle(80);
        chk("ovf_nwrites", wr_addr.size(), 2);
        if (wr_addr.size() == 2) chk("ovf_second_addr", wr_addr[1], 20);
        chk("ovf_lost_untouched", int'(ram[21]), 3);
        chk("ovf_sticky", int'(overflow), 1);

        // Reset during DRAW, with P2 also holding a hit.
        begin
            int n = 0;
            preload(5, 2'd1);
            clear_logs(); ack_delay = 30;
            pulse(1, 10'd20, 10'd0);
            while (!draw_req && n < 10) begin tick(); n++; end
            chk("rd_draw_req_up", int'(draw_req), 1);
            pulse(2, 10'd8, 10'd6);
            chk("rd_left_before", int'(bricks_left), 62);
            resetn = 1'b0;
            #1;
            chk("rd_draw_req", int'(draw_req), 0);
            chk("rd_bricks_left", int'(bricks_left), 64);
            chk("rd_busy", int'(busy), 0);
            chk("rd_overflow", int'(overflow), 0);
            tick();
            clear_logs();
            resetn = 1'b1;
            for (int k = 0; k < 6; k++) tick();
            chk("rd_no_writes_after", wr_addr.size(), 0);
            chk("rd_idle_after", int'(busy), 0);
        end

        // Clear the whole field.
        ack_delay = 0;
        for (int i = 0; i < 64; i++) preload(i, 2'd1);
        clear_logs();
        for (int i = 0; i < 64; i++) begin
            pulse(1, 10'((i % 16) * 4), 10'((i / 16) * 2));
            wait_idle(20);
        end
        chk("clr_nwrites", wr_addr.size(), 64);
        chk("clr_bricks_left", int'(bricks_left), 0);
        chk("clr_all_cleared", int'(all_cleared), 1);
        clear_logs();
        pulse(2, 10'd0, 10'd0);
        wait_idle(20);
        chk("clr_dead_no_write", wr_addr.size(), 0);
        chk("clr_dead_no_draw", dr_x.size(), 0);
        chk("clr_left_sat", int'(bricks_left), 0);

        chk("draw_stable", stab_err, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
